// File: rtl/counter_seq_monitor_if.sv
// counter_seq_monitor_if
// Counter-side signals observed by counter_seq_monitor plus the monitor's
// status outputs. The master modport drives the counter view (testbench or
// counter wrapper); the slave modport is the monitor itself.
interface counter_seq_monitor_if #(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8,
   parameter int ERR_W  = 8
);
   logic              count_en;
   logic              cnt_clr;
   logic [WIDTH-1:0]  q_in;
   logic              in_sync;
   logic              err_pulse;
   logic [ERR_W-1:0]  err_count;
   logic              wrap_pulse;
   logic [WRAP_W-1:0] wrap_count;
   logic [WIDTH-1:0]  exp_q;

   modport master (
      output count_en, cnt_clr, q_in,
      input  in_sync, err_pulse, err_count, wrap_pulse, wrap_count, exp_q
   );

   modport slave (
      input  count_en, cnt_clr, q_in,
      output in_sync, err_pulse, err_count, wrap_pulse, wrap_count, exp_q
   );
endinterface

// File: rtl/counter_seq_monitor.sv
// counter_seq_monitor
// Watches a free-running counter's registered output and enable, checks that
// every sample follows from the previous one, counts legal wraps and
// mismatches, and reports whether it is locked.
// Optional feature macro: COUNTER_SEQ_MON_RESYNC_EN
//   defined   -> ERROR lasts one cycle, the monitor recaptures and relocks
//   undefined -> ERROR is sticky until reset, counters frozen
module counter_seq_monitor #(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8,
   parameter int ERR_W  = 8
) (
   input logic                  clk,
   input logic                  reset,
   counter_seq_monitor_if.slave mon
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      ERROR = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] Q_ALL_ONES = '1;
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  prev_q;
   logic              prev_en;
   logic              prev_clr;
   logic              capture;

   logic              in_sync_r,    in_sync_nxt;
   logic              err_pulse_r,  err_pulse_nxt;
   logic              wrap_pulse_r, wrap_pulse_nxt;
   logic [ERR_W-1:0]  err_count_r,  err_count_nxt;
   logic [WRAP_W-1:0] wrap_count_r, wrap_count_nxt;
   logic [WIDTH-1:0]  exp_q_r,      exp_q_nxt;

   logic [WIDTH-1:0]  cur_exp;
   logic [WIDTH-1:0]  sample_exp;
   logic              match;
   logic              legal_wrap;

   // Expectation for this cycle's sample, and the one this sample implies for the next cycle.
   always_comb begin
      cur_exp    = prev_clr ? '0 : prev_q + WIDTH'(prev_en);
      sample_exp = mon.cnt_clr ? '0 : mon.q_in + WIDTH'(mon.count_en);
      match      = (mon.q_in == cur_exp);
      legal_wrap = (prev_q == Q_ALL_ONES) && prev_en && !prev_clr && (mon.q_in == '0);
   end

   // Next state and next values of every registered output.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
      state_nxt      = state;
      capture        = 1'b0;
      in_sync_nxt    = 1'b0;
      err_pulse_nxt  = 1'b0;
      wrap_pulse_nxt = 1'b0;
      err_count_nxt  = err_count_r;
      wrap_count_nxt = wrap_count_r;
      exp_q_nxt      = '0;

      unique case (state)
         IDLE: begin
            // First sample after reset only seeds the tracker; in_sync rises one edge later.
            capture   = 1'b1;
            exp_q_nxt = sample_exp;
            state_nxt = TRACK;
         end
         TRACK: begin
            if (match) begin
               capture     = 1'b1;
               in_sync_nxt = 1'b1;
               exp_q_nxt   = sample_exp;
               if (legal_wrap) begin
                  wrap_pulse_nxt = 1'b1;
                  wrap_count_nxt = wrap_count_r + WRAP_W'(1);
               end
            end else begin
               state_nxt     = ERROR;
               err_pulse_nxt = 1'b1;
               if (err_count_r != ERR_MAX) begin
                  err_count_nxt = err_count_r + ERR_W'(1);
               end
`ifdef COUNTER_SEQ_MON_RESYNC_EN
               // Keep following the offending sample so exp_q stays meaningful during ERROR.
               capture   = 1'b1;
               exp_q_nxt = sample_exp;
`endif
            end
         end
         ERROR: begin
`ifdef COUNTER_SEQ_MON_RESYNC_EN
            // One-cycle recovery: recapture and relock without comparing.
            capture     = 1'b1;
            exp_q_nxt   = sample_exp;
            in_sync_nxt = 1'b1;
            state_nxt   = TRACK;
`else
            state_nxt   = ERROR;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, captured sample and output registers; synchronous reset clears all of them.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values and updates together.
      if (reset) begin
         state        <= IDLE;
         prev_q       <= '0;
         prev_en      <= 1'b0;
         prev_clr     <= 1'b0;
         in_sync_r    <= 1'b0;
         err_pulse_r  <= 1'b0;
         wrap_pulse_r <= 1'b0;
         err_count_r  <= '0;
         wrap_count_r <= '0;
         exp_q_r      <= '0;
      end else begin
         state        <= state_nxt;
         if (capture) begin
            prev_q   <= mon.q_in;
            prev_en  <= mon.count_en;
            prev_clr <= mon.cnt_clr;
         end
         in_sync_r    <= in_sync_nxt;
         err_pulse_r  <= err_pulse_nxt;
         wrap_pulse_r <= wrap_pulse_nxt;
         err_count_r  <= err_count_nxt;
         wrap_count_r <= wrap_count_nxt;
         exp_q_r      <= exp_q_nxt;
      end
   end

   assign mon.in_sync    = in_sync_r;
   assign mon.err_pulse  = err_pulse_r;
   assign mon.wrap_pulse = wrap_pulse_r;
   assign mon.err_count  = err_count_r;
   assign mon.wrap_count = wrap_count_r;
   assign mon.exp_q      = exp_q_r;

endmodule

// File: doc/counter_seq_monitor.md
# counter_seq_monitor

Observer for the 4-bit counter interface: it samples the counter's output (`q_out`) and its enable each clock and checks that the count sequence is correct. It counts wrap-arounds (15→0), flags and counts sequence errors, and tracks whether it is locked to the counter. It sits beside `counter_4bit` on the same counter interface as its reader, and is used in both benches and on-chip debug.

## Interface
- `WIDTH`, default 4: counter width.
- `WRAP_W`, default 8: wrap counter width.
- `ERR_W`, default 8: error counter width.
- `clk`, input, 1: sole clock; every register updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `count_en`, input, 1: the counter's enable, exactly as the counter samples it.
- `cnt_clr`, input, 1: the counter is being cleared this cycle, so its next `q_out` must be 0.
- `q_in`, input, WIDTH: the counter's registered output (`q_out`).
- `in_sync`, output, 1: the monitor is locked and comparing.
- `err_pulse`, output, 1: one-cycle pulse for each detected mismatch.
- `err_count`, output, ERR_W: total mismatches; saturates at all-ones.
- `wrap_pulse`, output, 1: one-cycle pulse for each legal wrap from all-ones to 0.
- `wrap_count`, output, WRAP_W: total wraps; rolls over modulo 2^WRAP_W.
- `exp_q`, output, WIDTH: expected value of `q_in` in the current cycle.

## Operation
- Internal registers: `prev_q`, `prev_en`, `prev_clr`, and the state.
- Expected value: `exp_q` = 0 if `prev_clr`; otherwise `prev_q + prev_en` modulo 2^WIDTH.
- `cnt_clr` has priority over the enable in this rule.
- States:
  - IDLE: entered on reset. On the first non-reset edge, capture `q_in`, `count_en` and `cnt_clr`, then go to TRACK. No comparison is made in IDLE.
  - TRACK: compare `q_in` against `exp_q` every cycle.
    - Match: stay in TRACK and update the `prev_*` registers.
    - Mismatch: go to ERROR, pulse `err_pulse`, and increment `err_count` unless it is already saturated.
  - ERROR: behaviour is set by the macro (see Configuration).
- Legal wrap: in TRACK with `prev_q` = all-ones, `prev_en` = 1, `prev_clr` = 0 and `q_in` = 0.
  - Effect: pulse `wrap_pulse` and increment `wrap_count`.
  - A return to 0 caused by `cnt_clr` is not a wrap.
  - A mismatching 0 is not a wrap.
- `in_sync` = 1 only in TRACK.
- `exp_q` reads 0 in IDLE, and in ERROR when ERROR is sticky.
- Arithmetic:
  - `exp_q` wraps modulo 2^WIDTH.
  - `err_count` saturates.
  - `wrap_count` wraps.
  - `err_pulse` and `wrap_pulse` are never asserted in the same cycle.

## Timing
- All outputs are registered. Reset values: `in_sync` = 0, `err_pulse` = 0, `wrap_pulse` = 0, `err_count` = 0, `wrap_count` = 0, `exp_q` = 0, state IDLE.
- Cycle numbering: the first edge with `reset` = 0 is edge 0.
  - Edge 0: sample captured.
  - Edge 1: `in_sync` = 1.
  - The first comparison uses `q_in` as sampled at edge 1.
- Detection latency is one cycle:
  - A mismatching `q_in` sampled at edge k gives `err_pulse` = 1 during cycle k+1.
  - The `err_count` increment is visible from cycle k+1.
  - `wrap_pulse` and `wrap_count` follow the same timing.
- A reset asserted mid-operation clears everything on that edge, including the counters and the `prev_*` registers. The monitor relocks two edges after `reset` is released.
- With `count_en` = 0 and `cnt_clr` = 0, `q_in` must hold its value; any change is an error.
- If `cnt_clr` = 1 and `count_en` = 1 together, the expected next value is 0.

## Configuration
- Macro: `COUNTER_SEQ_MON_RESYNC_EN`.
- Defined (auto-resync):
  - ERROR lasts exactly one cycle. In that cycle, recapture `q_in`, `count_en` and `cnt_clr`, then return to TRACK.
  - `in_sync` is 0 for exactly one cycle after each error pulse.
  - A mismatch that persists gives at most one error per two cycles.
- Undefined (sticky):
  - ERROR holds until `reset`.
  - `in_sync` = 0 and `err_pulse` = 0 while in ERROR.
  - `err_count` and `wrap_count` are frozen.

## Test plan
- Reset, then `count_en` = 1 continuously for 20 cycles with a correct counter (0..15, 0..3) → `err_count` = 0, `wrap_count` = 1, `wrap_pulse` high for exactly one cycle (the cycle after `q_in` = 0 is sampled), `in_sync` = 1 from edge 1.
- Toggle `count_en` every 8 cycles and hold `q_in` while it is 0 → no errors, and `exp_q` tracks `q_in` every cycle.
- Force `q_in` = 7 where 5 is expected → `err_pulse` for one cycle, `err_count` = 1. Resync build: `in_sync` low for one cycle, then tracks from 7. Sticky build: `in_sync` stays 0 until reset.
- Counter at 15 with `cnt_clr` = 1 and `count_en` = 1, next `q_in` = 0 → no `wrap_pulse`, no error, `wrap_count` unchanged.
- Resync build: inject 300 mismatches → `err_count` saturates at 255, and `err_pulse` still fires for each one.
- Assert `reset` for one cycle mid-count at `q_in` = 9 → all outputs 0 on that edge, then relock with no error at the next values 9, 10, ...
